// File: rtl/rom_image_loader.sv
// Boot loader: requests the BASIC, CHARGEN and KERNAL images from the SPI flash reader,
// writes each streamed byte to its C64 address, and holds the CPU in reset until all three have landed.
`timescale 1ns/1ps
module rom_image_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h300000,
    parameter int          BASIC_LEN  = 8192,
    parameter int          CHAR_LEN   = 4096,
    parameter int          KERNAL_LEN = 8192,
    parameter int          TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    output logic        rd_start,
    output logic [23:0] rd_addr,
    output logic [15:0] rd_len,
    input  logic        rd_busy,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [15:0] sum,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_STREAM = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  seg;
    logic [15:0] count;
    logic [15:0] tmo;
    logic        busy_q;
    logic        accept;
    logic        last_byte;
    logic        busy_fall;
    logic        timed_out;

    function automatic logic [23:0] seg_flash(input logic [1:0] s);
        case (s)
            2'd0:    seg_flash = FLASH_BASE;
            2'd1:    seg_flash = FLASH_BASE + 24'(BASIC_LEN);
            default: seg_flash = FLASH_BASE + 24'(BASIC_LEN + CHAR_LEN);
        endcase
    endfunction

    function automatic logic [15:0] seg_len(input logic [1:0] s);
        case (s)
            2'd0:    seg_len = 16'(BASIC_LEN);
            2'd1:    seg_len = 16'(CHAR_LEN);
            default: seg_len = 16'(KERNAL_LEN);
        endcase
    endfunction

    function automatic logic [15:0] seg_base(input logic [1:0] s);
        case (s)
            2'd0:    seg_base = 16'hA000;
            2'd1:    seg_base = 16'hD000;
            default: seg_base = 16'hE000;
        endcase
    endfunction

    // Byte stream handshake: a byte transfers on every rising edge where in_valid and
    // in_ready are both high; in_ready is high in every STREAM cycle and nowhere else,
    // and the reader may raise or drop in_valid freely between transfers.
    assign in_ready  = (state == S_STREAM);
    assign accept    = in_valid & in_ready;
    assign last_byte = (count == rd_len - 16'd1);
    // busy_q is forced low outside STREAM, so a reader still finishing a previous
    // segment cannot look like an abort on the first STREAM cycle.
    assign busy_fall = busy_q & ~rd_busy;
    assign timed_out = ~accept & (tmo == 16'(TIMEOUT - 1));
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            seg      <= 2'd0;
            count    <= 16'd0;
            tmo      <= 16'd0;
            busy_q   <= 1'b0;
            rd_start <= 1'b0;
            rd_addr  <= 24'd0;
            rd_len   <= 16'd0;
            mem_we   <= 1'b0;
            mem_addr <= 16'd0;
            mem_data <= 8'd0;
            sum      <= 16'd0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            rd_start <= 1'b0;
            mem_we   <= 1'b0;
            busy_q   <= (state == S_STREAM) ? rd_busy : 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        sum      <= 16'd0;
                        error    <= 1'b0;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                        seg      <= 2'd0;
                        rd_addr  <= seg_flash(2'd0);
                        rd_len   <= seg_len(2'd0);
                        rd_start <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    count <= 16'd0;
                    tmo   <= 16'd0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        mem_we   <= 1'b1;
                        mem_addr <= seg_base(seg) + count;
                        mem_data <= in_data;
                        sum      <= sum + {8'h00, in_data};
                        count    <= count + 16'd1;
                        tmo      <= 16'd0;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                    // A completing byte wins over a simultaneous abort; otherwise count < len holds here.
                    if (accept && last_byte) begin
                        state <= S_NEXT;
                    end else if (busy_fall || timed_out) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_NEXT: begin
                    if (seg == 2'd2) begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        seg      <= seg + 2'd1;
                        rd_addr  <= seg_flash(seg + 2'd1);
                        rd_len   <= seg_len(seg + 2'd1);
                        rd_start <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed bench for rom_image_loader: full loads, gapped stream, reader abort, timeout and mid-load reset.
`timescale 1ns/1ps
module tb_rom_image_loader;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_STREAM = 3'd2,
                           ST_NEXT = 3'd3, ST_DONE = 3'd4, ST_ERR = 3'd5;
    localparam int TOTAL = 20480;

    logic        clk = 1'b0;
    logic        reset, go, rd_busy, in_valid;
    logic [7:0]  in_data;
    logic        rd_start, in_ready, mem_we, done, error, cpu_hold;
    logic [23:0] rd_addr;
    logic [15:0] rd_len, mem_addr, sum;
    logic [7:0]  mem_data;
    logic [2:0]  state_dbg;

    logic        t_go, t_rd_busy, t_in_valid;
    logic [7:0]  t_in_data;
    logic        t_rd_start, t_in_ready, t_mem_we, t_done, t_error, t_cpu_hold;
    logic [23:0] t_rd_addr;
    logic [15:0] t_rd_len, t_mem_addr, t_sum;
    logic [7:0]  t_mem_data;
    logic [2:0]  t_state_dbg;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    int          t_wr_cnt = 0;
    logic [15:0] exp_sum;
    logic [23:0] exp_q[$];

    logic [23:0] seg_fa [3] = '{24'h300000, 24'h302000, 24'h303000};
    int          seg_ln [3] = '{8192, 4096, 8192};
    logic [15:0] seg_ma [3] = '{16'hA000, 16'hD000, 16'hE000};

    // clock / reset
    always #5 clk = ~clk;

    rom_image_loader u_dut (
        .clk(clk), .reset(reset), .go(go),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .sum(sum), .done(done), .error(error), .cpu_hold(cpu_hold), .state_dbg(state_dbg)
    );

    rom_image_loader #(.TIMEOUT(16)) u_tmo (
        .clk(clk), .reset(reset), .go(t_go),
        .rd_start(t_rd_start), .rd_addr(t_rd_addr), .rd_len(t_rd_len), .rd_busy(t_rd_busy),
        .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_data(t_mem_data),
        .sum(t_sum), .done(t_done), .error(t_error), .cpu_hold(t_cpu_hold), .state_dbg(t_state_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // scoreboard: every write must match the oldest byte the reader handed over
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("mem_write", 64'({mem_addr, mem_data}), 64'(exp_q.pop_front()));
        end
        if (t_mem_we === 1'b1) t_wr_cnt++;
    end

    // driver tasks
    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic start_load();
        exp_sum = 16'd0;
        wr_cnt  = 0;
        pulse_go();
    endtask

    task automatic serve(input int s, input int n, input bit gaps);
        int         lat = 0;
        int         gap;
        logic [7:0] d;
        logic [23:0] fa;
        while (rd_start !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("rd_start_lat_seg%0d", s), 64'(lat), 64'((s == 0) ? 0 : 1));
        chk($sformatf("rd_addr_seg%0d", s), 64'(rd_addr), 64'(seg_fa[s]));
        chk($sformatf("rd_len_seg%0d", s), 64'(rd_len), 64'(seg_ln[s]));
        rd_busy = 1'b1;
        @(negedge clk);
        chk($sformatf("rd_start_width_seg%0d", s), 64'(rd_start), 64'd0);
        chk($sformatf("in_ready_first_seg%0d", s), 64'(in_ready), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 63) == 0) begin
                in_valid = 1'b0;
                gap = $urandom_range(1, 20);
                repeat (gap) @(negedge clk);
            end
            fa = seg_fa[s] + 24'(i);
            d  = fa[7:0];
            in_valid = 1'b1;
            in_data  = d;
            exp_q.push_back({seg_ma[s] + 16'(i), d});
            exp_sum += {8'h00, d};
            @(negedge clk);
        end
        in_valid = 1'b0;
        rd_busy  = 1'b0;
        chk($sformatf("rd_addr_held_seg%0d", s), 64'(rd_addr), 64'(seg_fa[s]));
    endtask

    task automatic run_load(input bit gaps, input int cut_seg, input int cut_n);
        for (int s = 0; s < 3; s++) begin
            serve(s, (s == cut_seg) ? cut_n : seg_ln[s], gaps);
            if (s == cut_seg) return;
        end
    endtask

    task automatic check_full(input string tag);
        chk({tag, "_next_state"}, 64'(state_dbg), 64'(ST_NEXT));
        chk({tag, "_done_early"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_state"}, 64'(state_dbg), 64'(ST_DONE));
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_writes"}, 64'(wr_cnt), 64'(TOTAL));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_start"}, 64'(rd_start), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_rd_len"}, 64'(rd_len), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_data"}, 64'(mem_data), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
    endtask

    initial begin
        int w;
        reset = 1'b0; go = 1'b0; rd_busy = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        t_go = 1'b0; t_rd_busy = 1'b0; t_in_valid = 1'b0; t_in_data = 8'h00;
        exp_sum = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        chk("t_por_cpu_hold", 64'(t_cpu_hold), 64'd1);
        reset = 1'b1;
        @(negedge clk);

        // timeout instance: bytes offered in IDLE are ignored
        t_in_valid = 1'b1; t_in_data = 8'h5A;
        repeat (4) @(negedge clk);
        chk("t_idle_writes", 64'(t_wr_cnt), 64'd0);
        chk("t_idle_in_ready", 64'(t_in_ready), 64'd0);
        chk("t_idle_sum", 64'(t_sum), 64'd0);
        t_in_valid = 1'b0;
        t_go = 1'b1;
        @(negedge clk);
        t_go = 1'b0;
        chk("t_rd_start", 64'(t_rd_start), 64'd1);
        chk("t_state_req", 64'(t_state_dbg), 64'(ST_REQ));
        t_rd_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            t_go = (i == 4);
            @(negedge clk);
        end
        t_go = 1'b0;
        chk("t_stream_after_15", 64'(t_state_dbg), 64'(ST_STREAM));
        chk("t_error_after_15", 64'(t_error), 64'd0);
        @(negedge clk);
        chk("t_state_err_16", 64'(t_state_dbg), 64'(ST_ERR));
        chk("t_error_16", 64'(t_error), 64'd1);
        chk("t_cpu_hold_err", 64'(t_cpu_hold), 64'd1);
        chk("t_done_err", 64'(t_done), 64'd0);
        t_in_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("t_err_writes", 64'(t_wr_cnt), 64'd0);
        chk("t_err_in_ready", 64'(t_in_ready), 64'd0);
        chk("t_err_state", 64'(t_state_dbg), 64'(ST_ERR));
        t_in_valid = 1'b0;

        // reset mid-segment 2
        start_load();
        run_load(1'b0, 2, 10);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid_reset");
        chk("mid_reset_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // clean full load after reset release
        start_load();
        run_load(1'b0, -1, 0);
        check_full("full");

        // reader drops rd_busy after 100 bytes of segment 1
        start_load();
        run_load(1'b0, 1, 100);
        w = 0;
        while (error !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("abort_error", 64'(error), 64'd1);
        chk("abort_state", 64'(state_dbg), 64'(ST_ERR));
        chk("abort_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_writes", 64'(wr_cnt), 64'd8292);
        chk("abort_sum", 64'(sum), 64'(exp_sum));
        in_valid = 1'b1; in_data = 8'hC3;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("err_ignores_bytes", 64'(wr_cnt), 64'd8292);
        chk("err_in_ready", 64'(in_ready), 64'd0);

        // reload from ERR with random in_valid gaps
        start_load();
        chk("reload_error_cleared", 64'(error), 64'd0);
        run_load(1'b1, -1, 0);
        check_full("gapped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_image_loader.md
# rom_image_loader

Boot-time loader sitting directly downstream of the SPI flash reader block. It issues read requests for the three C64 ROM images (BASIC, CHARGEN, KERNAL) stored back-to-back in configuration flash, accepts the returned byte stream over a valid/ready handshake, and writes each byte into system memory at the image's C64 address. It holds the CPU in reset until all images are loaded, and flags truncated or stalled transfers.

## Interface
- FLASH_BASE, 24'h300000, flash byte address of the first image (BASIC)
- BASIC_LEN, 8192, bytes in BASIC image, loaded to 16'hA000
- CHAR_LEN, 4096, bytes in CHARGEN image, loaded to 16'hD000
- KERNAL_LEN, 8192, bytes in KERNAL image, loaded to 16'hE000
- TIMEOUT, 65535, max idle cycles in a stream before error (16-bit counter)

- clk  in  1  system clock (clk_out of the clock wizard)
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- go  in  1  start load; sampled only in IDLE
- rd_start  out  1  one-cycle request pulse to SPI reader
- rd_addr  out  24  flash start address of current segment
- rd_len  out  16  byte count of current segment
- rd_busy  in  1  SPI reader transfer in progress
- in_data  in  8  byte from SPI reader
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  16  memory write address
- mem_data  out  8  memory write data
- sum  out  16  modulo-65536 sum of all bytes accepted since go
- done  out  1  all segments loaded
- error  out  1  segment aborted (sticky until reset or next go)
- cpu_hold  out  1  CPU reset hold

## Operation
- Reset values: rd_start 0, rd_addr 0, rd_len 0, in_ready 0, mem_we 0, mem_addr 0, mem_data 0, sum 0, done 0, error 0, cpu_hold 1; state IDLE, seg 0.
- Segment table (seg index 0..2): 0 = {FLASH_BASE, BASIC_LEN, A000}; 1 = {FLASH_BASE+BASIC_LEN, CHAR_LEN, D000}; 2 = {FLASH_BASE+BASIC_LEN+CHAR_LEN, KERNAL_LEN, E000}.
- States: IDLE, REQ, STREAM, NEXT, DONE, ERR.
- IDLE: go=1 -> clear sum/error/done, seg=0, cpu_hold=1, -> REQ.
- REQ: drive rd_addr/rd_len from table (held stable through STREAM), rd_start=1 one cycle, byte count=0, timeout counter=0 -> STREAM.
- STREAM: in_ready=1. Accept = in_valid & in_ready. On accept: mem_addr=base+count, mem_data=in_data, sum+=in_data, count++, timeout=0. Byte where count==len-1 -> NEXT.
- Abort in STREAM: registered falling edge of rd_busy with count<len, or timeout counter reaching TIMEOUT -> ERR. Accept in the same cycle as abort detect is still written, then ERR.
- NEXT: seg<2 -> seg++, REQ; seg==2 -> DONE.
- DONE: done=1, cpu_hold=0; go=1 restarts as from IDLE.
- ERR: error=1, cpu_hold=1, in_ready=0; go=1 restarts as from IDLE.
- in_valid outside STREAM ignored (in_ready=0, no write, no sum update).
- go in any state other than IDLE/DONE/ERR ignored.
- Reset mid-operation: immediate return to reset values; partially written memory not cleared.

## Timing
- rd_start asserted exactly one cycle after go sampled (IDLE->REQ), and one cycle after NEXT for segments 1 and 2.
- in_ready combinational from state (high in all STREAM cycles, including first).
- Write latency: mem_we/mem_addr/mem_data registered, valid the cycle after the accepting edge, mem_we high for exactly one cycle per accepted byte.
- Back-to-back accepts give back-to-back mem_we pulses; no bubbles.
- Last byte of segment 2: mem_we cycle coincides with NEXT; done=1 and cpu_hold=0 one cycle later.
- Minimum total load: 20480 accepts + 3 REQ + 3 NEXT + 1 IDLE cycles.
- Timeout counts cycles in STREAM without accept; ERR entered on cycle TIMEOUT.

## Test plan
- Reset then go, reader model streams 8192/4096/8192 bytes with in_valid always 1, data = addr[7:0] -> 20480 writes, addresses A000-BFFF, D000-DFFF, E000-FFFF, done=1, cpu_hold=0, sum matches model.
- Check requests -> rd_addr 300000/302000/303000, rd_len 8192/4096/8192, each rd_start exactly one cycle.
- Random in_valid gaps (0-20 cycles) -> identical memory image and sum, no duplicate or dropped writes.
- Reader drops rd_busy after 100 bytes of segment 1 -> error=1, cpu_hold=1, done=0, exactly 8292 writes; go -> clean full reload.
- TIMEOUT=16, in_valid held 0 in segment 0 -> ERR after 16 idle cycles; in_valid during IDLE/ERR -> no writes.
- Assert reset mid-segment 2 -> all outputs at reset values same cycle; go after release -> full reload succeeds.
